// File: rtl/tile_loop_pkg.sv
// tile_loop_pkg: shared types and phase-length helpers for the tile loop controller.
//   state_e    - controller FSM state encoding
//   wload_len  - cycles spent loading one ARR x ARR weight tile
//   drain_len  - cycles from end of feed until the last adder enable has fallen
//   wback_len  - cycles spent writing back one ARR-row result tile
package tile_loop_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StCheck,
        StWload,
        StFeed,
        StDrain,
        StWback,
        StNext,
        StDoneHi,
        StDoneWait
    } state_e;

    function automatic int unsigned wload_len(int unsigned arr);
        return arr * arr;
    endfunction

    function automatic int unsigned drain_len(int unsigned arr, int unsigned pipe_lat);
        return arr + pipe_lat - 1;
    endfunction

    function automatic int unsigned wback_len(int unsigned arr);
        return arr;
    endfunction

endpackage

// File: rtl/tile_idx_cnt.sv
// tile_idx_cnt: triple nested tile index counter, h innermost, then i, then j.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   clear             - force all indices to 0
//   step              - advance to the next (h, i, j) tile
//   m_cnt/n_cnt/k_cnt - tile counts (must be non-zero while stepping)
//   i_idx/j_idx/h_idx - current indices
//   last              - current indices are the final tile of the job
module tile_idx_cnt #(
    parameter int unsigned DIM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step,
    input  logic [DIM_W-1:0] m_cnt,
    input  logic [DIM_W-1:0] n_cnt,
    input  logic [DIM_W-1:0] k_cnt,
    output logic [DIM_W-1:0] i_idx,
    output logic [DIM_W-1:0] j_idx,
    output logic [DIM_W-1:0] h_idx,
    output logic             last
);

    logic [DIM_W-1:0] i_q, j_q, h_q;
    logic             h_wrap, i_wrap, j_wrap;

    // Compare against count-1 rather than idx+1 == count so an all-ones count never overflows.
    assign h_wrap = (h_q == k_cnt - 1'b1);
    assign i_wrap = (i_q == m_cnt - 1'b1);
    assign j_wrap = (j_q == n_cnt - 1'b1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            i_q <= '0;
            j_q <= '0;
            h_q <= '0;
        end else if (step) begin
            if (h_wrap) begin
                h_q <= '0;
                if (i_wrap) begin
                    i_q <= '0;
                    j_q <= j_wrap ? '0 : j_q + 1'b1;
                end else begin
                    i_q <= i_q + 1'b1;
                end
            end else begin
                h_q <= h_q + 1'b1;
            end
        end
    end

    assign i_idx = i_q;
    assign j_idx = j_q;
    assign h_idx = h_q;
    assign last  = h_wrap && i_wrap && j_wrap;

endmodule

// File: rtl/tile_loop_ctrl.sv
// tile_loop_ctrl: sequences a tiled matrix job over an ARR x ARR systolic array.
// Per (i, j, h) tile: load weights, feed activations, drain the PE pipeline;
// after the last h of an (i, j) pair the result tile is written back.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   start                     - job request (level), ignored while a job runs
//   m_tiles/n_tiles/k_tiles   - tile counts, latched on an accepted start
//   err_found                 - external configuration error, sampled in CHECK
//   done, busy, err           - job complete, job active, sticky error
//   i_idx/j_idx/h_idx         - current tile indices
//   w_vld, w_row, wshift      - weight-row load strobe, row select, column shift
//   a_vld                     - activation feed strobe
//   pe_en, mul_en, adder_en   - per-column wavefront enables
//   o_vld, o_row              - result write strobe and row select
//   cyc_cnt                   - busy cycle counter, only with TILE_LOOP_CTRL_PERF_EN defined
// All strobes and enables are flops loaded from the next state, so they assert in
// the first cycle of their state.
module tile_loop_ctrl
    import tile_loop_pkg::*;
#(
    parameter int unsigned ARR      = 4,
    parameter int unsigned DIM_W    = 8,
    parameter int unsigned PIPE_LAT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DIM_W-1:0]        m_tiles,
    input  logic [DIM_W-1:0]        n_tiles,
    input  logic [DIM_W-1:0]        k_tiles,
    input  logic                    err_found,
    output logic                    done,
    output logic                    busy,
    output logic                    err,
    output logic [DIM_W-1:0]        i_idx,
    output logic [DIM_W-1:0]        j_idx,
    output logic [DIM_W-1:0]        h_idx,
    output logic                    w_vld,
    output logic [$clog2(ARR)-1:0]  w_row,
    output logic                    wshift,
    output logic                    a_vld,
    output logic [ARR-1:0]          pe_en,
    output logic [ARR-1:0]          mul_en,
    output logic [ARR-1:0]          adder_en,
    output logic                    o_vld,
    output logic [$clog2(ARR)-1:0]  o_row
`ifdef TILE_LOOP_CTRL_PERF_EN
    ,
    output logic [31:0]             cyc_cnt
`endif
);

    localparam int unsigned RW       = $clog2(ARR);
    localparam int unsigned WloadLen = wload_len(ARR);
    localparam int unsigned DrainLen = drain_len(ARR, PIPE_LAT);
    localparam int unsigned WbackLen = wback_len(ARR);
    localparam int unsigned CntW     = $clog2(WloadLen + DrainLen + 1);
    localparam int unsigned AddDly   = PIPE_LAT - 1;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DIM_W-1:0]  m_q, n_q, k_q;
    logic              accept, cfg_bad, idx_clear, idx_step, idx_last, h_last, timed;
    logic              done_q, busy_q, err_q, w_vld_q, wshift_q, a_vld_q, o_vld_q;
    logic [RW-1:0]     w_row_q, o_row_q;
    logic [ARR-1:0]    pe_en_q, mul_en_q;

    tile_idx_cnt #(
        .DIM_W(DIM_W)
    ) u_idx (
        .clk  (clk),
        .rst  (rst),
        .clear(idx_clear),
        .step (idx_step),
        .m_cnt(m_q),
        .n_cnt(n_q),
        .k_cnt(k_q),
        .i_idx(i_idx),
        .j_idx(j_idx),
        .h_idx(h_idx),
        .last (idx_last)
    );

    assign h_last  = (h_idx == k_q - 1'b1);
    assign cfg_bad = err_found || (m_q == '0) || (n_q == '0) || (k_q == '0);

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        idx_clear = 1'b0;
        idx_step  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                idx_clear = !cfg_bad;
                state_d   = cfg_bad ? StDoneHi : StWload;
            end
            StWload: if (cnt_q == CntW'(WloadLen - 1)) state_d = StFeed;
            StFeed:  if (cnt_q == CntW'(ARR - 1))      state_d = StDrain;
            StDrain: if (cnt_q == CntW'(DrainLen - 1)) state_d = h_last ? StWback : StNext;
            StWback: if (cnt_q == CntW'(WbackLen - 1)) state_d = StNext;
            StNext: begin
                if (idx_last) begin
                    state_d = StDoneHi;
                end else begin
                    idx_step = 1'b1;
                    state_d  = StWload;
                end
            end
            StDoneHi:   state_d = StDoneWait;
            StDoneWait: if (!start) state_d = StIdle;
            default:    state_d = StIdle;
        endcase

        // Phase counters restart on every state entry; row_d tracks cnt_d mod ARR.
        timed = (state_d inside {StWload, StFeed, StDrain, StWback});
        if (!timed || (state_d != state_q)) begin
            cnt_d = '0;
            row_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
            row_d = (row_q == RW'(ARR - 1)) ? '0 : row_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            row_q    <= '0;
            m_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            w_vld_q  <= 1'b0;
            w_row_q  <= '0;
            wshift_q <= 1'b0;
            a_vld_q  <= 1'b0;
            o_vld_q  <= 1'b0;
            o_row_q  <= '0;
            pe_en_q  <= '0;
            mul_en_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            if (accept) begin
                m_q <= m_tiles;
                n_q <= n_tiles;
                k_q <= k_tiles;
            end
            if (accept) begin
                err_q <= 1'b0;
            end else if ((state_q == StCheck) && cfg_bad) begin
                err_q <= 1'b1;
            end
            done_q   <= (state_d inside {StDoneHi, StDoneWait});
            busy_q   <= !(state_d inside {StIdle, StDoneHi, StDoneWait});
            w_vld_q  <= (state_d == StWload);
            w_row_q  <= (state_d == StWload) ? row_d : '0;
            wshift_q <= (state_d == StWload) && (row_d == RW'(ARR - 1));
            a_vld_q  <= (state_d == StFeed);
            o_vld_q  <= (state_d == StWback);
            o_row_q  <= (state_d == StWback) ? row_d : '0;
            // Column c sees the feed window c cycles later: a diagonal wavefront.
            pe_en_q  <= {pe_en_q[ARR-2:0], (state_d == StFeed)};
            mul_en_q <= pe_en_q;
        end
    end

    generate
        if (AddDly == 0) begin : g_add_direct
            assign adder_en = pe_en_q;
        end else begin : g_add_dly
            logic [ARR-1:0] dly_q [AddDly];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned s = 0; s < AddDly; s++) dly_q[s] <= '0;
                end else begin
                    dly_q[0] <= pe_en_q;
                    for (int unsigned s = 1; s < AddDly; s++) dly_q[s] <= dly_q[s-1];
                end
            end
            assign adder_en = dly_q[AddDly-1];
        end
    endgenerate

`ifdef TILE_LOOP_CTRL_PERF_EN
    logic [31:0] cyc_q;
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            cyc_q <= '0;
        end else if (busy_q && (cyc_q != '1)) begin
            cyc_q <= cyc_q + 1'b1;
        end
    end
    assign cyc_cnt = cyc_q;
`endif

    assign done   = done_q;
    assign busy   = busy_q;
    assign err    = err_q;
    assign w_vld  = w_vld_q;
    assign w_row  = w_row_q;
    assign wshift = wshift_q;
    assign a_vld  = a_vld_q;
    assign pe_en  = pe_en_q;
    assign mul_en = mul_en_q;
    assign o_vld  = o_vld_q;
    assign o_row  = o_row_q;

endmodule

// File: tb/tb_tile_loop_ctrl.sv
// tb_tile_loop_ctrl: table-driven jobs on an ARR=4 instance plus hand-written
// reset, done-handshake and ARR=8 wavefront sequences. Define TILE_LOOP_CTRL_PERF_EN
// to also check cyc_cnt.
module tb_tile_loop_ctrl;

    localparam int ARR = 4;
    localparam int PL  = 3;

    logic       clk, rst, start, start8, err_found;
    logic [7:0] m, n, k;

    logic       done, busy, err, w_vld, wshift, a_vld, o_vld;
    logic [7:0] i_idx, j_idx, h_idx;
    logic [1:0] w_row, o_row;
    logic [3:0] pe_en, mul_en, adder_en;

    logic       done8, busy8, err8, w_vld8, wshift8, a_vld8, o_vld8;
    logic [7:0] i_idx8, j_idx8, h_idx8;
    logic [2:0] w_row8, o_row8;
    logic [7:0] pe_en8, mul_en8, adder_en8;
`ifdef TILE_LOOP_CTRL_PERF_EN
    logic [31:0] cyc_cnt, cyc_cnt8;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;

    tile_loop_ctrl #(.ARR(4), .DIM_W(8), .PIPE_LAT(3)) dut (
        .clk(clk), .rst(rst), .start(start), .m_tiles(m), .n_tiles(n), .k_tiles(k),
        .err_found(err_found), .done(done), .busy(busy), .err(err),
        .i_idx(i_idx), .j_idx(j_idx), .h_idx(h_idx),
        .w_vld(w_vld), .w_row(w_row), .wshift(wshift), .a_vld(a_vld),
        .pe_en(pe_en), .mul_en(mul_en), .adder_en(adder_en), .o_vld(o_vld), .o_row(o_row)
`ifdef TILE_LOOP_CTRL_PERF_EN
        , .cyc_cnt(cyc_cnt)
`endif
    );

    tile_loop_ctrl #(.ARR(8), .DIM_W(8), .PIPE_LAT(3)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .m_tiles(m), .n_tiles(n), .k_tiles(k),
        .err_found(err_found), .done(done8), .busy(busy8), .err(err8),
        .i_idx(i_idx8), .j_idx(j_idx8), .h_idx(h_idx8),
        .w_vld(w_vld8), .w_row(w_row8), .wshift(wshift8), .a_vld(a_vld8),
        .pe_en(pe_en8), .mul_en(mul_en8), .adder_en(adder_en8), .o_vld(o_vld8),
        .o_row(o_row8)
`ifdef TILE_LOOP_CTRL_PERF_EN
        , .cyc_cnt(cyc_cnt8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int m, n, k;
        bit ef;
        int busy_n, bursts, wv, av;
        bit err;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic longint outs4();
        return longint'({done, busy, err, i_idx, j_idx, h_idx, w_vld, w_row, wshift, a_vld,
                         pe_en, mul_en, adder_en, o_vld, o_row});
    endfunction

    // Expected enable vector t cycles after FEED start, shifted by d cycles of delay.
    function automatic int wave(input int t, input int d);
        int r = 0;
        for (int c = 0; c < ARR; c++)
            if ((t - d >= c) && (t - d <= c + ARR - 1)) r |= (1 << c);
        return r;
    endfunction

    task automatic run_job(input int mm, input int nn, input int kk, input bit ef,
                           output int nb, output int nburst, output int nw, output int na,
                           output bit e_end);
        int  t, wi, oi, hexp;
        bit  prev_a, prev_o, fin;
        nb = 0; nburst = 0; nw = 0; na = 0; e_end = 0;
        t = -100000; wi = 0; oi = 0; hexp = 0; prev_a = 0; prev_o = 0; fin = 0;
        m = 8'(mm); n = 8'(nn); k = 8'(kk); err_found = ef; start = 1'b1;
        for (int cyc = 0; cyc < 10000 && !fin; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 0) begin
                chk("err_cleared_on_start", err, 0);
`ifdef TILE_LOOP_CTRL_PERF_EN
                chk("cyc_cnt_cleared", cyc_cnt, 0);
`endif
            end
            if (busy) nb++;
            if (a_vld && !prev_a) begin
                chk("h_order", h_idx, hexp);
                hexp++;
                t = 0;
            end
            if (o_vld && !prev_o) begin
                nburst++;
                chk("h_passes_before_burst", hexp, kk);
                hexp = 0;
            end
            chk("pe_en", pe_en, wave(t, 0));
            chk("mul_en", mul_en, wave(t, 1));
            chk("adder_en", adder_en, wave(t, PL - 1));
            if (w_vld) begin
                chk("wshift_wrow", {wshift, w_row}, ((wi % ARR == ARR - 1) ? 4 : 0) + wi % ARR);
                wi++;
                nw++;
            end
            if (o_vld) begin
                chk("o_row", o_row, oi % ARR);
                oi++;
            end
            if (a_vld) na++;
            prev_a = a_vld;
            prev_o = o_vld;
            t++;
            if (done) fin = 1;
        end
        chk("job_completes", fin, 1);
        e_end = err;
`ifdef TILE_LOOP_CTRL_PERF_EN
        chk("cyc_cnt_eq_busy", cyc_cnt, nb);
`endif
        repeat (2) begin
            @(posedge clk); #1;
            chk("done_hold", {done, busy}, 2);
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk("done_drop", {done, busy}, 0);
    endtask

    vec_t vecs[8];

    initial begin
        int  nb, nburst, nw, na, t0, t7, ws8, b8;
        bit  e_end, fin;
        logic [7:0] prev_pe8;

        vecs[0] = '{1, 1, 1,   0, 32,   1, 16,   4,    0};
        vecs[1] = '{2, 1, 3,   0, 171,  2, 96,   24,   0};
        vecs[2] = '{1, 2, 2,   0, 117,  2, 64,   16,   0};
        vecs[3] = '{1, 1, 0,   0, 1,    0, 0,    0,    1};
        vecs[4] = '{1, 1, 1,   1, 1,    0, 0,    0,    1};
        vecs[5] = '{0, 3, 3,   0, 1,    0, 0,    0,    1};
        vecs[6] = '{3, 2, 1,   0, 187,  6, 96,   24,   0};
        vecs[7] = '{1, 1, 255, 0, 6890, 1, 4080, 1020, 0};

        rst = 1'b1; start = 1'b0; start8 = 1'b0; err_found = 1'b0; m = 0; n = 0; k = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", outs4(), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("first_cycle_idle", outs4(), 0);

        for (int v = 0; v < 8; v++) begin
            run_job(vecs[v].m, vecs[v].n, vecs[v].k, vecs[v].ef, nb, nburst, nw, na, e_end);
            chk($sformatf("v%0d_busy_cycles", v), nb, vecs[v].busy_n);
            chk($sformatf("v%0d_obursts", v), nburst, vecs[v].bursts);
            chk($sformatf("v%0d_w_vld", v), nw, vecs[v].wv);
            chk($sformatf("v%0d_a_vld", v), na, vecs[v].av);
            chk($sformatf("v%0d_err", v), e_end, vecs[v].err);
        end

        // Reset in the middle of FEED, then a clean job.
        m = 1; n = 1; k = 1; err_found = 1'b0; start = 1'b1;
        fin = 0;
        for (int c = 0; c < 100 && !fin; c++) begin
            @(posedge clk); #1;
            if (a_vld) fin = 1;
        end
        chk("reached_feed", fin, 1);
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        chk("midjob_reset_outputs", outs4(), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("after_reset_idle", outs4(), 0);
        run_job(1, 1, 1, 0, nb, nburst, nw, na, e_end);
        chk("clean_job_busy", nb, 32);
        chk("clean_job_bursts", nburst, 1);

        // ARR=8 wavefront and weight shifts.
        m = 1; n = 1; k = 1; start8 = 1'b1;
        t0 = -1; t7 = -1; ws8 = 0; b8 = 0; fin = 0; prev_pe8 = '0;
        for (int c = 0; c < 500 && !fin; c++) begin
            @(posedge clk); #1;
            if (busy8) b8++;
            if (wshift8) ws8++;
            if (pe_en8[0] && !prev_pe8[0]) t0 = c;
            if (pe_en8[7] && !prev_pe8[7]) t7 = c;
            prev_pe8 = pe_en8;
            if (done8) fin = 1;
        end
        chk("arr8_done", fin, 1);
        chk("arr8_pe7_lag", t7 - t0, 7);
        chk("arr8_wshift_pulses", ws8, 8);
        chk("arr8_busy_cycles", b8, 92);
`ifdef TILE_LOOP_CTRL_PERF_EN
        chk("arr8_cyc_cnt", cyc_cnt8, b8);
`endif
        start8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("arr8_idle_after", {done8, busy8}, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/tile_loop_ctrl.md
TILE_LOOP_CTRL -- requirements
Module: tile_loop_ctrl

Interface
REQ-001 SHALL have parameter ARR, default 4: systolic array dimension (rows = cols = ARR), legal 2..16.
REQ-002 SHALL have parameter DIM_W, default 8: width of the tile-count inputs and loop indices.
REQ-003 SHALL have parameter PIPE_LAT, default 3: PE multiply-add pipeline depth in cycles.
REQ-004 SHALL have these ports: clk in 1 clock; rst in 1 synchronous active-high reset; start in 1 job request (level); m_tiles, n_tiles, k_tiles in DIM_W each, tile counts; err_found in 1 external configuration error.
REQ-005 SHALL have these outputs: done out 1 job complete; busy out 1 job active; err out 1 error sticky; i_idx, j_idx, h_idx out DIM_W each, current tile indices.
REQ-006 SHALL have these outputs: w_vld out 1 weight-row load strobe; w_row out $clog2(ARR) weight row select; wshift out 1 weight column shift.
REQ-007 SHALL have these outputs: a_vld out 1 activation feed strobe; pe_en, mul_en, adder_en out ARR each, per-column enables; o_vld out 1 result write strobe; o_row out $clog2(ARR) result row select.

Function
REQ-008 SHALL implement FSM states IDLE, CHECK, WLOAD, FEED, DRAIN, WBACK, NEXT, DONE_HI, DONE_WAIT.
REQ-009 IDLE SHALL go to CHECK on start=1, latching m_tiles/n_tiles/k_tiles.
REQ-010 CHECK SHALL go to DONE_HI with err=1 if err_found=1 or any latched count is 0; otherwise it SHALL go to WLOAD with i_idx=j_idx=h_idx=0.
REQ-011 WLOAD SHALL last ARR*ARR cycles, pulsing w_vld every cycle with w_row = cycle mod ARR, and SHALL assert wshift on the last cycle of each ARR-cycle group.
REQ-012 FEED SHALL last ARR cycles with a_vld=1; pe_en SHALL be a diagonal wavefront, so bit c is set from FEED cycle c through FEED cycle c+ARR-1, continuing into DRAIN.
REQ-013 mul_en SHALL be pe_en delayed 1 cycle; adder_en SHALL be pe_en delayed PIPE_LAT-1 cycles.
REQ-014 DRAIN SHALL last ARR+PIPE_LAT-1 cycles, until all adder_en bits have returned to 0.
REQ-015 After DRAIN, the FSM SHALL go to WBACK only when h_idx = k_tiles-1; otherwise it SHALL go to NEXT.
REQ-016 WBACK SHALL last ARR cycles with o_vld=1 and o_row = 0..ARR-1.
REQ-017 NEXT SHALL advance h, then i, then j, with h innermost, each index wrapping to 0 at its count-1; after the last j it SHALL go to DONE_HI, otherwise to WLOAD.
REQ-018 DONE_HI SHALL hold done=1 for one cycle, then go to DONE_WAIT.
REQ-019 DONE_WAIT SHALL keep done=1 until start=0, then return to IDLE.
REQ-020 busy SHALL be 1 in every state except IDLE, DONE_HI and DONE_WAIT.
REQ-021 Every strobe and enable output SHALL be registered, so it asserts in the first cycle of its state with no added latency.
REQ-022 start asserted while busy=1 SHALL be ignored.
REQ-023 err SHALL clear only on the next accepted start.
REQ-024 Counts equal to 2^DIM_W-1 SHALL NOT overflow the index compare.

Reset
REQ-025 rst=1 on a clock edge SHALL force IDLE from any state, including mid-job.
REQ-026 rst SHALL set every output to 0 and clear the latched counts and indices.
REQ-027 The first cycle after reset is released SHALL be IDLE, with no spurious strobes.

Configuration
REQ-028 With macro TILE_LOOP_CTRL_PERF_EN defined, the block SHALL add output cyc_cnt (32 bits), which clears on an accepted start, increments on every busy=1 cycle, holds its value after done, and saturates at all-ones.
REQ-029 Without TILE_LOOP_CTRL_PERF_EN, cyc_cnt and its counter SHALL be absent.

Structure
REQ-030 Package tile_loop_pkg SHALL hold the state enum type and the phase length functions wload_len(ARR), drain_len(ARR, PIPE_LAT) and wback_len(ARR).
REQ-031 The triple nested index counter SHALL be the sub-module tile_idx_cnt, with inputs clear, step and the three counts, and outputs i/j/h indices and last.
REQ-032 The wavefront shift register for pe_en/mul_en/adder_en SHALL stay inside tile_loop_ctrl.

Verification
REQ-033 ARR=4, PIPE_LAT=3, m=n=k=1, start held: busy for 16+4+6+4 plus CHECK/NEXT cycles, then done=1 until start drops.
REQ-034 m=2, n=1, k=3: o_vld bursts occur exactly 2 times, each 4 cycles long, and h_idx cycles 0,1,2 before each burst.
REQ-035 k_tiles=0 with start: the CHECK to DONE_HI path is taken with err=1, and w_vld/a_vld/o_vld are never asserted.
REQ-036 rst pulsed during FEED: the next cycle shows IDLE, all outputs 0; a new start then runs a clean job.
REQ-037 ARR=8: pe_en bit 7 rises 7 cycles after bit 0; wshift pulses 8 times in WLOAD.
REQ-038 With TILE_LOOP_CTRL_PERF_EN, the REQ-033 job gives cyc_cnt equal to the busy cycle count; a second start clears it.
